// File: rtl/nri_div_datapath_if.sv
// Execute-stage divider bus: FSM-side drive (enable, index, op, operands) and datapath result.
interface nri_div_datapath_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned K    = 4
);
   localparam int unsigned J = (K > 1) ? $clog2(K) : 1;

   logic            i_we;
   logic [J-1:0]    i_index;
   logic [1:0]      i_op;
   logic [XLEN-1:0] i_dividend;
   logic [XLEN-1:0] i_divisor;
   logic [XLEN-1:0] o_result;
   logic            o_valid;

   modport master (
      output i_we, i_index, i_op, i_dividend, i_divisor,
      input  o_result, o_valid
   );

   modport slave (
      input  i_we, i_index, i_op, i_dividend, i_divisor,
      output o_result, o_valid
   );
endinterface

// File: rtl/nri_div_datapath.sv
// Iterative non-restoring divider datapath for RV32M DIV/DIVU/REM/REMU.
// Retires XLEN/K quotient bits per enabled cycle; sign/zero fix-up follows the last step.
module nri_div_datapath #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned K    = 4
) (
   input logic               i_clk,
   input logic               i_rst,
   nri_div_datapath_if.slave bus
);
   localparam int unsigned S = XLEN / K;
   localparam int unsigned J = (K > 1) ? $clog2(K) : 1;

   if (K < 2 || (XLEN % K) != 0) begin : g_param_check
      $error("nri_div_datapath: K must be >= 2 and divide XLEN");
   end

   logic [XLEN:0]   r_q;
   logic [XLEN-1:0] q_q, d_q, raw_q, result_q;
   logic            rem_q, neg_q_q, neg_r_q, dz_q, final_q, valid_q;

   logic            load, is_last, signed_op;
   logic [XLEN-1:0] abs_dividend, abs_divisor;
   logic [XLEN:0]   r_step, r_shift;
   logic [XLEN-1:0] q_step, d_step;
   logic [XLEN-1:0] r_fix, quotient, remainder, fix_result;

   assign load         = bus.i_we && (bus.i_index == '0);
   assign is_last      = (bus.i_index == J'(K - 1));
   assign signed_op    = ~bus.i_op[0];
   assign abs_dividend = (signed_op && bus.i_dividend[XLEN-1]) ? -bus.i_dividend
                                                                : bus.i_dividend;
   assign abs_divisor  = (signed_op && bus.i_divisor[XLEN-1]) ? -bus.i_divisor
                                                               : bus.i_divisor;

   // S chained steps; on a load the seeded values feed the chain directly.
   always_comb begin
      r_step  = load ? '0 : r_q;
      q_step  = load ? abs_dividend : q_q;
      d_step  = load ? abs_divisor : d_q;
      r_shift = '0;
      for (int s = 0; s < S; s++) begin
         r_shift = {r_step[XLEN-1:0], q_step[XLEN-1]};
         r_step  = r_step[XLEN] ? r_shift + {1'b0, d_step} : r_shift - {1'b0, d_step};
         q_step  = {q_step[XLEN-2:0], ~r_step[XLEN]};
      end
   end

   // Final remainder lies in [0, D) after correction, so XLEN bits suffice.
   always_comb begin
      r_fix     = r_q[XLEN] ? r_q[XLEN-1:0] + d_q : r_q[XLEN-1:0];
      quotient  = neg_q_q ? -q_q : q_q;
      remainder = neg_r_q ? -r_fix : r_fix;
      if (dz_q) begin
         fix_result = rem_q ? raw_q : '1;
      end else begin
         fix_result = rem_q ? remainder : quotient;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q      <= '0;
         q_q      <= '0;
         d_q      <= '0;
         raw_q    <= '0;
         result_q <= '0;
         rem_q    <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         final_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= final_q;
         final_q <= bus.i_we && is_last;
         if (final_q) begin
            result_q <= fix_result;
         end
         if (bus.i_we) begin
            r_q <= r_step;
            q_q <= q_step;
         end
         if (load) begin
            d_q     <= abs_divisor;
            raw_q   <= bus.i_dividend;
            rem_q   <= bus.i_op[1];
            neg_q_q <= signed_op && (bus.i_dividend[XLEN-1] ^ bus.i_divisor[XLEN-1]);
            neg_r_q <= signed_op && bus.i_dividend[XLEN-1];
            dz_q    <= (bus.i_divisor == '0);
         end
      end
   end

   assign bus.o_result = result_q;
   assign bus.o_valid  = valid_q;
endmodule

// File: tb/tb_nri_div_datapath.sv
// Self-checking bench for nri_div_datapath: directed vectors, stalls, reset abort,
// back-to-back loads and a randomized sweep against an arithmetic reference model.
module tb_nri_div_datapath;
   parameter int unsigned K = 4;
   localparam int unsigned XLEN = 32;
   localparam int unsigned J = (K > 1) ? $clog2(K) : 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef struct {
      logic [1:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   logic [XLEN-1:0] last_res = '0;

   nri_div_datapath_if #(.XLEN(XLEN), .K(K)) bus ();
   nri_div_datapath #(.XLEN(XLEN), .K(K)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation exceeded time limit, n_fail=%0d", n_fail);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // RISC-V M-extension semantics from plain arithmetic.
   function automatic logic [XLEN-1:0] ref_model(input logic [1:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa, sb;
      sa = a;
      sb = b;
      if (b == '0) return op[1] ? a : '1;
      case (op)
         2'b00:   return (a == MIN && b == '1) ? MIN : XLEN'(sa / sb);
         2'b01:   return a / b;
         2'b10:   return (a == MIN && b == '1) ? '0 : XLEN'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] rand_operand();
      case ($urandom_range(7))
         0:       return '0;
         1:       return MIN;
         2:       return '1;
         3:       return XLEN'($urandom_range(20));
         4:       return -XLEN'($urandom_range(20));
         default: return XLEN'($urandom);
      endcase
   endfunction

   // Drives one operation (optionally with random enable drops) and observes the result.
   // cyc is the cycle valid was seen in, with the load cycle as cycle 0 (-1 if never).
   task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int stall_pct, output logic [XLEN-1:0] res, output int cyc,
                        output bit early, output bit linger, output int stalls);
      int c;
      int idx;
      res = 'x;
      cyc = -1;
      early = 1'b0;
      linger = 1'b0;
      stalls = 0;
      bus.i_we = 1'b1;
      bus.i_index = '0;
      bus.i_op = op;
      bus.i_dividend = a;
      bus.i_divisor = b;
      tick();
      c = 1;
      if (bus.o_valid) early = 1'b1;
      idx = 1;
      while (idx < int'(K)) begin
         if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
            bus.i_we = 1'b0;
            bus.i_index = J'($urandom);
            stalls++;
         end else begin
            bus.i_we = 1'b1;
            bus.i_index = J'(idx);
            idx++;
         end
         bus.i_op = 2'($urandom);
         bus.i_dividend = XLEN'($urandom);
         bus.i_divisor = XLEN'($urandom);
         tick();
         c++;
         if (bus.o_valid) early = 1'b1;
      end
      bus.i_we = 1'b0;
      bus.i_index = J'($urandom);
      for (int w = 0; w < 12; w++) begin
         tick();
         c++;
         if (bus.o_valid) begin
            res = bus.o_result;
            cyc = c;
            break;
         end
      end
      tick();
      linger = bus.o_valid;
   endtask

   task automatic test_reset();
      bus.i_we = 1'b0;
      bus.i_index = '0;
      bus.i_op = 2'b00;
      bus.i_dividend = '0;
      bus.i_divisor = '0;
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.o_result !== '0) begin
         n_fail++;
         $display("FAIL reset_result: got %h want %h", bus.o_result, '0);
      end
      n_checks++;
      if (bus.o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", bus.o_valid);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      vec_t tbl[5];
      logic [XLEN-1:0] res;
      int cyc, stalls;
      bit early, linger;
      tbl = '{'{2'b01, 32'd100, 32'd7, 32'd14},
              '{2'b11, 32'd100, 32'd7, 32'd2},
              '{2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2},
              '{2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE},
              '{2'b10, 32'd100, 32'hFFFFFFF9, 32'd2}};
      foreach (tbl[i]) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, res, cyc, early, linger, stalls);
         n_checks++;
         if (res !== tbl[i].e) begin
            n_fail++;
            $display("FAIL basic_result[%0d]: got %h want %h", i, res, tbl[i].e);
         end
         n_checks++;
         if (cyc !== int'(K) + 1 || early) begin
            n_fail++;
            $display("FAIL basic_latency[%0d]: got cycle %0d early=%0b want %0d", i, cyc, early,
                     K + 1);
         end
         n_checks++;
         if (linger !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse[%0d]: valid high 2 cycles, want 1", i);
         end
         last_res = tbl[i].e;
      end
   endtask

   task automatic test_div_zero();
      vec_t tbl[3];
      logic [XLEN-1:0] res;
      int cyc, stalls;
      bit early, linger;
      tbl = '{'{2'b00, 32'h12345678, 32'd0, 32'hFFFFFFFF},
              '{2'b11, 32'h12345678, 32'd0, 32'h12345678},
              '{2'b01, 32'd5, 32'd0, 32'hFFFFFFFF}};
      foreach (tbl[i]) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, res, cyc, early, linger, stalls);
         n_checks++;
         if (res !== tbl[i].e || cyc !== int'(K) + 1) begin
            n_fail++;
            $display("FAIL div_zero[%0d]: got %h at cycle %0d want %h at %0d", i, res, cyc,
                     tbl[i].e, K + 1);
         end
         last_res = tbl[i].e;
      end
   endtask

   task automatic test_overflow();
      vec_t tbl[3];
      logic [XLEN-1:0] res;
      int cyc, stalls;
      bit early, linger;
      tbl = '{'{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
              '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
              '{2'b01, 32'h80000000, 32'd1, 32'h80000000}};
      foreach (tbl[i]) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, res, cyc, early, linger, stalls);
         n_checks++;
         if (res !== tbl[i].e || cyc !== int'(K) + 1) begin
            n_fail++;
            $display("FAIL overflow[%0d]: got %h at cycle %0d want %h at %0d", i, res, cyc,
                     tbl[i].e, K + 1);
         end
         last_res = tbl[i].e;
      end
   endtask

   // DIVU 0xFFFFFFFF/3 with the enable dropped for 3 cycles before index 2.
   task automatic test_stall();
      int stall_at;
      int c;
      int cyc;
      bit bad_hold;
      bit early;
      logic [XLEN-1:0] res;
      stall_at = (K > 2) ? 2 : 1;
      bad_hold = 1'b0;
      early = 1'b0;
      cyc = -1;
      res = 'x;
      bus.i_we = 1'b1;
      bus.i_index = '0;
      bus.i_op = 2'b01;
      bus.i_dividend = 32'hFFFFFFFF;
      bus.i_divisor = 32'd3;
      tick();
      c = 1;
      for (int idx = 1; idx < int'(K); idx++) begin
         if (idx == stall_at) begin
            repeat (3) begin
               bus.i_we = 1'b0;
               bus.i_index = J'(idx);
               tick();
               c++;
               if (bus.o_valid) early = 1'b1;
               if (bus.o_result !== last_res) bad_hold = 1'b1;
            end
         end
         bus.i_we = 1'b1;
         bus.i_index = J'(idx);
         tick();
         c++;
         if (bus.o_valid) early = 1'b1;
         if (bus.o_result !== last_res) bad_hold = 1'b1;
      end
      bus.i_we = 1'b0;
      for (int w = 0; w < 12; w++) begin
         tick();
         c++;
         if (bus.o_valid) begin
            res = bus.o_result;
            cyc = c;
            break;
         end
         if (bus.o_result !== last_res) bad_hold = 1'b1;
      end
      n_checks++;
      if (res !== 32'h55555555) begin
         n_fail++;
         $display("FAIL stall_result: got %h want 55555555", res);
      end
      n_checks++;
      if (cyc !== int'(K) + 4 || early) begin
         n_fail++;
         $display("FAIL stall_latency: got cycle %0d early=%0b want %0d", cyc, early, K + 4);
      end
      n_checks++;
      if (bad_hold) begin
         n_fail++;
         $display("FAIL stall_hold: o_result changed before valid, want %h held", last_res);
      end
      last_res = 32'h55555555;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0] opa, opb;
      logic [XLEN-1:0] a, b, c, d, ea, eb;
      bit bad;
      for (int t = 0; t < 20; t++) begin
         opa = 2'($urandom);
         opb = 2'($urandom);
         a = rand_operand();
         b = rand_operand();
         c = rand_operand();
         d = rand_operand();
         ea = ref_model(opa, a, b);
         eb = ref_model(opb, c, d);
         bus.i_we = 1'b1;
         bus.i_index = '0;
         bus.i_op = opa;
         bus.i_dividend = a;
         bus.i_divisor = b;
         tick();
         for (int idx = 1; idx < int'(K); idx++) begin
            bus.i_index = J'(idx);
            tick();
         end
         bus.i_index = '0;
         bus.i_op = opb;
         bus.i_dividend = c;
         bus.i_divisor = d;
         tick();
         n_checks++;
         if (bus.o_valid !== 1'b1 || bus.o_result !== ea) begin
            n_fail++;
            $display("FAIL b2b_first[%0d]: valid=%b result %h want valid=1 %h", t, bus.o_valid,
                     bus.o_result, ea);
         end
         bad = 1'b0;
         for (int idx = 1; idx < int'(K); idx++) begin
            bus.i_index = J'(idx);
            bus.i_op = 2'($urandom);
            bus.i_dividend = XLEN'($urandom);
            tick();
            if (bus.o_valid !== 1'b0 || bus.o_result !== ea) bad = 1'b1;
         end
         n_checks++;
         if (bad) begin
            n_fail++;
            $display("FAIL b2b_gap[%0d]: valid or result moved during second op, want hold %h",
                     t, ea);
         end
         bus.i_we = 1'b0;
         tick();
         n_checks++;
         if (bus.o_valid !== 1'b1 || bus.o_result !== eb) begin
            n_fail++;
            $display("FAIL b2b_second[%0d]: valid=%b result %h want valid=1 %h", t, bus.o_valid,
                     bus.o_result, eb);
         end
         last_res = eb;
         tick();
      end
   endtask

   task automatic test_reset_midop();
      logic [XLEN-1:0] res;
      int cyc, stalls;
      bit early, linger, saw;
      bus.i_we = 1'b1;
      bus.i_index = '0;
      bus.i_op = 2'b11;
      bus.i_dividend = 32'hDEADBEEF;
      bus.i_divisor = 32'd1000;
      tick();
      bus.i_index = J'(1);
      rst = 1'b1;
      tick();
      n_checks++;
      if (bus.o_result !== '0 || bus.o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_state: result %h valid %b want 0 0", bus.o_result, bus.o_valid);
      end
      rst = 1'b0;
      bus.i_we = 1'b0;
      saw = 1'b0;
      repeat (K + 3) begin
         tick();
         if (bus.o_valid) saw = 1'b1;
      end
      n_checks++;
      if (saw || bus.o_result !== '0) begin
         n_fail++;
         $display("FAIL midreset_abort: valid seen=%0b result %h want 0 0", saw, bus.o_result);
      end
      do_op(2'b11, 32'd17, 32'd5, 0, res, cyc, early, linger, stalls);
      n_checks++;
      if (res !== 32'd2 || cyc !== int'(K) + 1) begin
         n_fail++;
         $display("FAIL midreset_next: got %h at cycle %0d want 2 at %0d", res, cyc, K + 1);
      end
      last_res = 32'd2;
   endtask

   task automatic test_random();
      logic [1:0] op;
      logic [XLEN-1:0] a, b, e, res;
      int cyc, stalls;
      bit early, linger;
      for (int t = 0; t < 200; t++) begin
         op = 2'($urandom);
         a = rand_operand();
         b = rand_operand();
         e = ref_model(op, a, b);
         do_op(op, a, b, 25, res, cyc, early, linger, stalls);
         n_checks++;
         if (res !== e) begin
            n_fail++;
            $display("FAIL random_result[%0d]: op=%0d %h/%h got %h want %h", t, op, a, b, res, e);
         end
         n_checks++;
         if (cyc !== int'(K) + 1 + stalls || early || linger) begin
            n_fail++;
            $display("FAIL random_timing[%0d]: cycle %0d early=%0b linger=%0b want %0d", t, cyc,
                     early, linger, int'(K) + 1 + stalls);
         end
         last_res = e;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_overflow();
      test_stall();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
